// File: rtl/injection_arbiter_if.sv
// Shared injection-port bundle: N_REQ flit sources on one side, router local port on the other.
// Signal suffixes are from the arbiter's point of view; the arbiter uses the slave modport.
interface injection_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int FLIT_SIZE = 32
);
  logic [N_REQ-1:0]                req_tx_i;
  logic [N_REQ-1:0]                req_eop_i;
  logic [N_REQ-1:0][FLIT_SIZE-1:0] req_data_i;
  logic [N_REQ-1:0]                req_credit_o;
  logic                            tx_o;
  logic                            credit_i;
  logic [FLIT_SIZE-1:0]            data_o;
  logic [N_REQ-1:0]                grant_o;
  logic                            busy_o;
  logic [15:0]                     flit_cnt_o;
  logic [31:0]                     pkt_cnt_o;

  modport slave (
    input  req_tx_i, req_eop_i, req_data_i, credit_i,
    output req_credit_o, tx_o, data_o, grant_o, busy_o, flit_cnt_o, pkt_cnt_o
  );

  modport master (
    output req_tx_i, req_eop_i, req_data_i, credit_i,
    input  req_credit_o, tx_o, data_o, grant_o, busy_o, flit_cnt_o, pkt_cnt_o
  );
endinterface

// File: rtl/injection_arbiter.sv
// Packet-atomic round-robin arbiter for one NoC injection port; grant registered one edge after request.
// Flits pass combinationally; router credit steers only to the granted source, one idle cycle after each EOP.
module injection_arbiter #(
  parameter int N_REQ     = 2,
  parameter int FLIT_SIZE = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  injection_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     grant_q;
  logic [PTR_W-1:0]     gidx_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [15:0]          flit_cnt_q;
  logic [31:0]          pkt_cnt_q;

  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;
  logic [N_REQ-1:0]     pick_onehot;
  logic                 tx_sel;
  logic [FLIT_SIZE-1:0] data_sel;
  logic [N_REQ-1:0]     credit_sel;
  logic                 xfer;
  logic                 eop_xfer;

  // Rotating priority: first requester at or above ptr_q, wrapping to 0.
  always_comb begin
    int               c;
    logic [PTR_W-1:0] c_idx;
    c           = 0;
    c_idx       = '0;
    pick_vld    = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c     = (int'(ptr_q) + i) % N_REQ;
      c_idx = PTR_W'(c);
      if (!pick_vld && bus.req_tx_i[c_idx]) begin
        pick_vld = 1'b1;
        pick_idx = c_idx;
      end
    end
    pick_onehot[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && pick_vld) begin
        grant_q <= pick_onehot;
        gidx_q  <= pick_idx;
      end else if (eop_xfer) begin
        grant_q    <= '0;
        ptr_q      <= (gidx_q == LAST_IDX) ? '0 : gidx_q + PTR_W'(1);
        pkt_cnt_q  <= pkt_cnt_q + 32'd1;
        flit_cnt_q <= '0;
      end else if (xfer) begin
        flit_cnt_q <= flit_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_GRANT;
      S_GRANT: if (eop_xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_sel     = 1'b0;
    data_sel   = '0;
    credit_sel = '0;
    if (state_q == S_GRANT) begin
      tx_sel             = bus.req_tx_i[gidx_q];
      data_sel           = bus.req_data_i[gidx_q];
      credit_sel[gidx_q] = bus.credit_i;
    end
  end

  assign xfer     = tx_sel & bus.credit_i;
  assign eop_xfer = xfer & bus.req_eop_i[gidx_q];

  assign bus.tx_o         = tx_sel;
  assign bus.data_o       = data_sel;
  assign bus.req_credit_o = credit_sel;
  assign bus.grant_o      = grant_q;
  assign bus.busy_o       = |grant_q;
  assign bus.flit_cnt_o   = flit_cnt_q;
  assign bus.pkt_cnt_o    = pkt_cnt_q;
endmodule
